// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and constants for the two-port DDR Avalon-MM arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 256;

  localparam logic [6:0]  AMM_BURSTCOUNT = 7'd1;
  localparam logic [31:0] AMM_BYTEENABLE = 32'hFFFF_FFFF;

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Avalon-MM bus between the arbiter (master) and the DDR controller (slave).
interface ddr_port_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] amm_addr;
  logic [DATA_W-1:0] amm_writedata;
  logic              amm_read;
  logic              amm_write;
  logic [31:0]       amm_byteenable;
  logic [6:0]        amm_burstcount;
  logic [DATA_W-1:0] amm_readdata;
  logic              amm_readdatavalid;
  logic              amm_ready;

  modport master (
    output amm_addr, amm_writedata, amm_read, amm_write, amm_byteenable, amm_burstcount,
    input  amm_readdata, amm_readdatavalid, amm_ready
  );

  modport slave (
    input  amm_addr, amm_writedata, amm_read, amm_write, amm_byteenable, amm_burstcount,
    output amm_readdata, amm_readdatavalid, amm_ready
  );
endinterface

// File: rtl/ddr_port_arbiter_select.sv
// Winner selection between the TX reader (0) and RX writer (1).
// DDR_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise requester 0 has fixed priority.
module ddr_arb_select (
  input  logic [1:0] req_valid,
`ifdef DDR_ARB_ROUND_ROBIN_EN
  input  logic       last_grant,
`endif
  output logic       any_req,
  output logic       winner
);

  assign any_req = |req_valid;

`ifdef DDR_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = req_valid[1];
    if (&req_valid) winner = ~last_grant;
  end
`else
  assign winner = req_valid[1] & ~req_valid[0];
`endif

endmodule

// File: rtl/ddr_port_arbiter.sv
// Two-requester arbiter issuing single-beat Avalon-MM reads/writes, one outstanding at a time.
// Optional macro DDR_ARB_ROUND_ROBIN_EN switches fixed priority to round-robin.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   avalon_clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_done,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   spurious_rd,
  ddr_port_arbiter_if.master     amm
);

  arb_state_t        state;
  logic              grant;
  logic              sel_any;
  logic              sel_win;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic last_grant;

  ddr_arb_select u_select (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .any_req    (sel_any),
    .winner     (sel_win)
  );
`else
  ddr_arb_select u_select (
    .req_valid (req_valid),
    .any_req   (sel_any),
    .winner    (sel_win)
  );
`endif

  assign amm.amm_addr       = addr_q;
  assign amm.amm_writedata  = wdata_q;
  assign amm.amm_read       = rd_q;
  assign amm.amm_write      = wr_q;
  assign amm.amm_byteenable = AMM_BYTEENABLE;
  assign amm.amm_burstcount = AMM_BURSTCOUNT;

  always_ff @(posedge avalon_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      req_done    <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      spurious_rd <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      req_done  <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (amm.amm_readdatavalid) spurious_rd <= 1'b1;
          if (sel_any) begin
            grant   <= sel_win;
            addr_q  <= req_addr[sel_win];
            wdata_q <= req_wdata[sel_win];
            wr_q    <= req_write[sel_win];
            rd_q    <= ~req_write[sel_win];
            state   <= CMD;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            last_grant <= sel_win;
`endif
          end
        end
        CMD: begin
          if (amm.amm_readdatavalid) spurious_rd <= 1'b1;
          if (amm.amm_ready) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (wr_q) begin
              req_done[grant] <= 1'b1;
              state           <= IDLE;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (amm.amm_readdatavalid) begin
            rsp_data         <= amm.amm_readdata;
            rsp_valid[grant] <= 1'b1;
            req_done[grant]  <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed self-checking bench for ddr_port_arbiter (honours DDR_ARB_ROUND_ROBIN_EN if defined).
module tb_ddr_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 256;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_write;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         req_done;
  logic [1:0]         rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               spurious_rd;

  int n_cmp = 0;
  int n_err = 0;

  ddr_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) amm_bus ();

  ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .avalon_clk  (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_done    (req_done),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .spurious_rd (spurious_rd),
    .amm         (amm_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    amm_bus.amm_readdata = '0; amm_bus.amm_readdatavalid = 1'b0; amm_bus.amm_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({amm_bus.amm_read, amm_bus.amm_write} !== 2'b00) begin n_err++; $display("FAIL reset_rdwr: got %b expected 00", {amm_bus.amm_read, amm_bus.amm_write}); end
    n_cmp++; if (amm_bus.amm_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h expected 0", amm_bus.amm_addr); end
    n_cmp++; if (amm_bus.amm_writedata !== '0) begin n_err++; $display("FAIL reset_wdata: got %0h expected 0", amm_bus.amm_writedata); end
    n_cmp++; if ({req_done, rsp_valid, spurious_rd} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 00000", {req_done, rsp_valid, spurious_rd}); end
    n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
    n_cmp++; if (amm_bus.amm_byteenable !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL byteenable: got %0h expected ffffffff", amm_bus.amm_byteenable); end
    n_cmp++; if (amm_bus.amm_burstcount !== 7'd1) begin n_err++; $display("FAIL burstcount: got %0d expected 1", amm_bus.amm_burstcount); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({amm_bus.amm_read, amm_bus.amm_write, req_done} !== 4'b0) begin n_err++; $display("FAIL idle_after_reset: got %b expected 0000", {amm_bus.amm_read, amm_bus.amm_write, req_done}); end
  endtask

  task automatic test_write();
    logic [DW-1:0] pat;
    pat = {32{8'hA5}};
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[1] = 25'h0000010; req_wdata[1] = pat;
    tick();
    n_cmp++; if ({amm_bus.amm_write, amm_bus.amm_read} !== 2'b10) begin n_err++; $display("FAIL wr_cmd: got %b expected 10", {amm_bus.amm_write, amm_bus.amm_read}); end
    n_cmp++; if (amm_bus.amm_addr !== 25'h0000010) begin n_err++; $display("FAIL wr_addr: got %0h expected 10", amm_bus.amm_addr); end
    n_cmp++; if (amm_bus.amm_writedata !== pat) begin n_err++; $display("FAIL wr_data: got %0h expected %0h", amm_bus.amm_writedata, pat); end
    n_cmp++; if (req_done !== 2'b00) begin n_err++; $display("FAIL wr_early_done: got %b expected 00", req_done); end
    amm_bus.amm_ready = 1'b1;
    tick();
    amm_bus.amm_ready = 1'b0;
    n_cmp++; if (req_done !== 2'b10) begin n_err++; $display("FAIL wr_done: got %b expected 10", req_done); end
    n_cmp++; if (amm_bus.amm_write !== 1'b0) begin n_err++; $display("FAIL wr_release: got %b expected 0", amm_bus.amm_write); end
    req_valid = 2'b00;
    tick();
    n_cmp++; if ({req_done, amm_bus.amm_write, amm_bus.amm_read} !== 4'b0) begin n_err++; $display("FAIL wr_after: got %b expected 0000", {req_done, amm_bus.amm_write, amm_bus.amm_read}); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] pat;
    pat = {8{32'hDEADBEEF}};
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0] = 25'h0ABCDEF; req_wdata[0] = pat;
    tick();
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (amm_bus.amm_write !== 1'b1 || amm_bus.amm_addr !== 25'h0ABCDEF || amm_bus.amm_writedata !== pat || req_done !== 2'b00) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: got wr=%b addr=%0h done=%b expected wr=1 addr=abcdef done=00", i, amm_bus.amm_write, amm_bus.amm_addr, req_done);
      end
      if (i == 10) amm_bus.amm_ready = 1'b1;
      tick();
    end
    amm_bus.amm_ready = 1'b0;
    n_cmp++; if (req_done !== 2'b01) begin n_err++; $display("FAIL stall_done: got %b expected 01", req_done); end
    req_valid = 2'b00;
    tick();
    n_cmp++; if ({req_done, amm_bus.amm_write} !== 3'b000) begin n_err++; $display("FAIL stall_single_accept: got %b expected 000", {req_done, amm_bus.amm_write}); end
  endtask

  task automatic test_read();
    req_valid = 2'b01; req_write = 2'b00;
    req_addr[0] = 25'h0001000;
    tick();
    n_cmp++; if ({amm_bus.amm_read, amm_bus.amm_write} !== 2'b10) begin n_err++; $display("FAIL rd_cmd: got %b expected 10", {amm_bus.amm_read, amm_bus.amm_write}); end
    n_cmp++; if (amm_bus.amm_addr !== 25'h0001000) begin n_err++; $display("FAIL rd_addr: got %0h expected 1000", amm_bus.amm_addr); end
    amm_bus.amm_ready = 1'b1;
    tick();
    amm_bus.amm_ready = 1'b0;
    n_cmp++; if ({amm_bus.amm_read, rsp_valid, req_done} !== 5'b0) begin n_err++; $display("FAIL rd_wait_entry: got %b expected 00000", {amm_bus.amm_read, rsp_valid, req_done}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({rsp_valid, req_done} !== 4'b0) begin n_err++; $display("FAIL rd_wait_quiet %0d: got %b expected 0000", i, {rsp_valid, req_done}); end
    end
    amm_bus.amm_readdata = 256'h1234; amm_bus.amm_readdatavalid = 1'b1;
    tick();
    amm_bus.amm_readdatavalid = 1'b0; amm_bus.amm_readdata = '0;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid: got %b expected 01", rsp_valid); end
    n_cmp++; if (req_done !== 2'b01) begin n_err++; $display("FAIL rd_done: got %b expected 01", req_done); end
    n_cmp++; if (rsp_data !== 256'h1234) begin n_err++; $display("FAIL rd_data: got %0h expected 1234", rsp_data); end
    req_valid = 2'b00;
    tick();
    n_cmp++; if ({rsp_valid, req_done, spurious_rd} !== 5'b0) begin n_err++; $display("FAIL rd_after: got %b expected 00000", {rsp_valid, req_done, spurious_rd}); end
  endtask

  task automatic test_spurious();
    amm_bus.amm_readdata = 256'hFFFF; amm_bus.amm_readdatavalid = 1'b1;
    tick();
    amm_bus.amm_readdatavalid = 1'b0; amm_bus.amm_readdata = '0;
    n_cmp++; if (spurious_rd !== 1'b1) begin n_err++; $display("FAIL spur_set: got %b expected 1", spurious_rd); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL spur_no_rsp: got %b expected 00", rsp_valid); end
    n_cmp++; if (rsp_data !== 256'h1234) begin n_err++; $display("FAIL spur_discard: got %0h expected 1234", rsp_data); end
    tick(); tick(); tick();
    n_cmp++; if (spurious_rd !== 1'b1) begin n_err++; $display("FAIL spur_sticky: got %b expected 1", spurious_rd); end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; req_write = 2'b00;
    req_addr[1] = 25'h0000055;
    tick();
    amm_bus.amm_ready = 1'b1;
    tick();
    amm_bus.amm_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0; req_valid = 2'b00;
    #1;
    n_cmp++; if ({amm_bus.amm_read, amm_bus.amm_write, req_done, rsp_valid, spurious_rd} !== 7'b0) begin n_err++; $display("FAIL midrst_flags: got %b expected 0000000", {amm_bus.amm_read, amm_bus.amm_write, req_done, rsp_valid, spurious_rd}); end
    n_cmp++; if (amm_bus.amm_addr !== '0 || amm_bus.amm_writedata !== '0 || rsp_data !== '0) begin n_err++; $display("FAIL midrst_data: got addr=%0h rsp=%0h expected 0", amm_bus.amm_addr, rsp_data); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (req_done !== 2'b00) begin n_err++; $display("FAIL midrst_no_done: got %b expected 00", req_done); end
    amm_bus.amm_readdata = 256'hBEEF; amm_bus.amm_readdatavalid = 1'b1;
    tick();
    amm_bus.amm_readdatavalid = 1'b0; amm_bus.amm_readdata = '0;
    n_cmp++; if (spurious_rd !== 1'b1) begin n_err++; $display("FAIL midrst_spur: got %b expected 1", spurious_rd); end
    n_cmp++; if ({rsp_valid, req_done} !== 4'b0) begin n_err++; $display("FAIL midrst_late_rsp: got %b expected 0000", {rsp_valid, req_done}); end
  endtask

  task automatic test_contention();
    int cnt [2];
    int ord [4];
    int expd [4];
    int n;
    int cyc;
    int w;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    expd = '{0, 1, 0, 1};
`else
    expd = '{0, 0, 1, 1};
`endif
    cnt = '{0, 0}; ord = '{-1, -1, -1, -1}; n = 0; cyc = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_write = 2'b11;
    req_addr[0] = 25'h100; req_addr[1] = 25'h200;
    req_wdata[0] = 256'h1; req_wdata[1] = 256'h2;
    amm_bus.amm_ready = 1'b1;
    req_valid = 2'b11;
    while (n < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (req_done != 2'b00) begin
        n_cmp++; if (req_done === 2'b11) begin n_err++; $display("FAIL cont_onehot: got %b expected one-hot", req_done); end
        w = req_done[1] ? 1 : 0;
        ord[n] = w;
        n++;
        cnt[w]++;
        if (cnt[w] == 2) req_valid[w] = 1'b0;
        else req_addr[w] = req_addr[w] + 25'd1;
      end
    end
    amm_bus.amm_ready = 1'b0;
    req_valid = 2'b00;
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL cont_timeout: got %0d completions expected 4", n); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ord[k] != expd[k]) begin n_err++; $display("FAIL cont_order[%0d]: got %0d expected %0d", k, ord[k], expd[k]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_stall();
    test_read();
    test_spurious();
    test_reset_mid();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
